// File: rtl/apb_arb_pkg.sv
// Shared definitions for the two-master APB arbiter: FSM state codes,
// grant encodings and the timeout counter sizing helper.
package apb_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SETUP  = 2'd1;
  localparam state_t ST_ACCESS = 2'd2;
  localparam state_t ST_RESP   = 2'd3;

  localparam logic GNT_M0 = 1'b0;
  localparam logic GNT_M1 = 1'b1;

  // Width of a counter that must hold values up to limit (never below one bit).
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 32'd2) ? 32'd1 : $clog2(limit + 32'd1);
  endfunction

endpackage

// File: rtl/apb_rr_pick.sv
// Two-way round-robin winner selection with the last-grant pointer.
module apb_rr_pick
  import apb_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       gnt_en,
  output logic       winner
);

  logic last_r;
  logic winner_s;

  // A lone requester wins outright; on a tie the one not granted last wins.
  always_comb begin
    winner_s = GNT_M0;
    case (req)
      2'b01:   winner_s = GNT_M0;
      2'b10:   winner_s = GNT_M1;
      2'b11:   winner_s = ~last_r;
      default: winner_s = GNT_M0;
    endcase
  end

  // Pointer moves only when a grant is actually issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_r <= GNT_M1;
    end else if (gnt_en) begin
      last_r <= winner_s;
    end
  end

  assign winner = winner_s;

endmodule

// File: rtl/apb_arbiter.sv
// Shares one APB master port between two requesters (m0 = CPU, m1 = DMA),
// replaying the winning transfer and aborting transfers that never complete.
module apb_arbiter
  import apb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 256
) (
  input  logic                  clk,
  input  logic                  APB_PRESET,
  input  logic [ADDR_WIDTH-1:0] m0_paddr,
  input  logic [DATA_WIDTH-1:0] m0_pdata,
  input  logic                  m0_psel,
  input  logic                  m0_penable,
  input  logic                  m0_pwrite,
  input  logic [3:0]            m0_pstb,
  output logic [DATA_WIDTH-1:0] m0_prdata,
  output logic                  m0_pready,
  output logic                  m0_perr,
  input  logic [ADDR_WIDTH-1:0] m1_paddr,
  input  logic [DATA_WIDTH-1:0] m1_pdata,
  input  logic                  m1_psel,
  input  logic                  m1_penable,
  input  logic                  m1_pwrite,
  input  logic [3:0]            m1_pstb,
  output logic [DATA_WIDTH-1:0] m1_prdata,
  output logic                  m1_pready,
  output logic                  m1_perr,
  output logic [ADDR_WIDTH-1:0] APB_paddr,
  output logic [DATA_WIDTH-1:0] APB_pdata,
  output logic                  APB_psel,
  output logic                  APB_penable,
  output logic                  APB_pwrite,
  output logic [3:0]            APB_pstb,
  input  logic [DATA_WIDTH-1:0] APB_prdata,
  input  logic                  APB_pready,
  input  logic                  APB_perr
);

  localparam int unsigned      CNT_W      = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic             TIMEOUT_EN = (TIMEOUT != 0);

  state_t           state_r;
  logic             win_r;
  logic [CNT_W-1:0] cnt_r;

  logic [1:0]            req_s;
  logic                  gnt_s;
  logic                  winner_s;
  logic                  expire_s;
  logic                  done_s;
  logic [DATA_WIDTH-1:0] resp_data_s;
  logic                  resp_err_s;
  logic                  unused_penable_s;

  // Requester penable carries no information for arbitration.
  assign unused_penable_s = m0_penable ^ m1_penable;

  assign req_s = {m1_psel, m0_psel};

  apb_rr_pick u_pick (
    .clk    (clk),
    .rst    (APB_PRESET),
    .req    (req_s),
    .gnt_en (gnt_s),
    .winner (winner_s)
  );

  // Grant, expiry and response selection; a real pready beats a same-cycle expiry.
  always_comb begin
    gnt_s       = (state_r == ST_IDLE) && (req_s != 2'b00);
    expire_s    = TIMEOUT_EN && (cnt_r == CNT_LAST);
    done_s      = (state_r == ST_ACCESS) && (APB_pready || expire_s);
    resp_data_s = '0;
    resp_err_s  = 1'b0;
    if (APB_pready) begin
      resp_data_s = APB_prdata;
      resp_err_s  = APB_perr;
    end else begin
      resp_data_s = '0;
      resp_err_s  = 1'b1;
    end
  end

  // Bus FSM: the captured transfer is driven straight from the APB output registers.
  always_ff @(posedge clk or posedge APB_PRESET) begin
    if (APB_PRESET) begin
      state_r     <= ST_IDLE;
      win_r       <= GNT_M0;
      cnt_r       <= '0;
      APB_paddr   <= '0;
      APB_pdata   <= '0;
      APB_psel    <= 1'b0;
      APB_penable <= 1'b0;
      APB_pwrite  <= 1'b0;
      APB_pstb    <= 4'h0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (gnt_s) begin
            state_r    <= ST_SETUP;
            win_r      <= winner_s;
            cnt_r      <= '0;
            APB_paddr  <= (winner_s == GNT_M1) ? m1_paddr  : m0_paddr;
            APB_pdata  <= (winner_s == GNT_M1) ? m1_pdata  : m0_pdata;
            APB_pwrite <= (winner_s == GNT_M1) ? m1_pwrite : m0_pwrite;
            APB_pstb   <= (winner_s == GNT_M1) ? m1_pstb   : m0_pstb;
            APB_psel   <= 1'b1;
          end
        end
        ST_SETUP: begin
          state_r     <= ST_ACCESS;
          APB_penable <= 1'b1;
        end
        ST_ACCESS: begin
          if (done_s) begin
            state_r     <= ST_RESP;
            APB_psel    <= 1'b0;
            APB_penable <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_RESP: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r     <= ST_IDLE;
          APB_psel    <= 1'b0;
          APB_penable <= 1'b0;
        end
      endcase
    end
  end

  // Response demux: a one-cycle pready to the winner; prdata holds between responses.
  always_ff @(posedge clk or posedge APB_PRESET) begin
    if (APB_PRESET) begin
      m0_pready <= 1'b0;
      m0_perr   <= 1'b0;
      m0_prdata <= '0;
      m1_pready <= 1'b0;
      m1_perr   <= 1'b0;
      m1_prdata <= '0;
    end else begin
      m0_pready <= 1'b0;
      m0_perr   <= 1'b0;
      m1_pready <= 1'b0;
      m1_perr   <= 1'b0;
      if (done_s && (win_r == GNT_M0)) begin
        m0_pready <= 1'b1;
        m0_perr   <= resp_err_s;
        m0_prdata <= resp_data_s;
      end
      if (done_s && (win_r == GNT_M1)) begin
        m1_pready <= 1'b1;
        m1_perr   <= resp_err_s;
        m1_prdata <= resp_data_s;
      end
    end
  end

endmodule

// File: doc/apb_arbiter.md
# apb_arbiter

Two-master arbiter that shares the single APB master port of the SoC between the CPU (port m0) and a second bus master such as a DMA engine (port m1). It sits between the masters and the `APB` decoder. Each master sees a standard APB completer interface. The arbiter replays the winning transfer on the shared bus, returns the registered response, and aborts transfers whose slave never answers.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- TIMEOUT, 256, max ACCESS cycles before abort; 0 disables the timeout

Ports:
- clk  in  1  system clock
- APB_PRESET  in  1  reset, asynchronous, active-high
- m0_paddr / m1_paddr  in  ADDR_WIDTH  requester address
- m0_pdata / m1_pdata  in  DATA_WIDTH  requester write data
- m0_psel / m1_psel  in  1  requester select
- m0_penable / m1_penable  in  1  requester enable
- m0_pwrite / m1_pwrite  in  1  requester write
- m0_pstb / m1_pstb  in  4  requester byte strobes
- m0_prdata / m1_prdata  out  DATA_WIDTH  read data returned to the requester
- m0_pready / m1_pready  out  1  transfer-complete pulse
- m0_perr / m1_perr  out  1  error, valid with pready
- APB_paddr  out  ADDR_WIDTH  shared-bus address
- APB_pdata  out  DATA_WIDTH  shared-bus write data
- APB_psel  out  1  shared-bus select
- APB_penable  out  1  shared-bus enable
- APB_pwrite  out  1  shared-bus write
- APB_pstb  out  4  shared-bus byte strobes
- APB_prdata  in  DATA_WIDTH  shared-bus read data
- APB_pready  in  1  shared-bus ready
- APB_perr  in  1  shared-bus error

## Operation
- State machine states: IDLE, SETUP, ACCESS, RESP.
- IDLE
  - A requester is pending when its mX_psel=1; penable is not examined.
  - If any requester is pending: pick a winner, capture its paddr, pdata, pwrite and pstb into registers, then go to SETUP.
- Winner selection
  - Only one pending: it wins.
  - Both pending: the requester that was not granted last wins (round-robin).
  - The last-grant pointer updates only on grant.
- SETUP: APB_psel=1, APB_penable=0, bus driven from the captured registers. Always moves to ACCESS after one cycle.
- ACCESS
  - APB_psel=1, APB_penable=1; the timeout counter increments each cycle.
  - APB_pready=1: latch APB_prdata and APB_perr, go to RESP.
  - Counter reaches TIMEOUT with no pready: latch prdata=0 and perr=1, go to RESP.
- RESP
  - The winner's mX_pready=1 for exactly one cycle, with latched mX_prdata and mX_perr. Then go to IDLE.
  - The loser's pready stays 0 throughout.
- Requesters are required to hold psel, paddr, pdata, pwrite and pstb stable until their pready.
  - The arbiter does not re-sample these after capture.
  - A requester that drops psel before its pready is a protocol violation; the captured transfer still completes.
- APB_pdata is held at the captured value for reads as well.
- mX_prdata holds its last value when pready=0.

## Timing
- Reset values
  - State = IDLE, last-grant = m1 (so m0 wins the first tie), timeout counter = 0.
  - All APB_* outputs 0; all mX_pready, mX_perr and mX_prdata outputs 0.
- Reset asserted mid-transfer: return to IDLE immediately (asynchronous). The aborted requester gets no pready.
- Latency
  - Requester psel seen in IDLE at cycle N: APB_psel at N+1, APB_penable at N+2.
  - Zero-wait slave (APB_pready at N+2): mX_pready at N+3.
  - Each slave wait state adds one cycle.
- Back-to-back
  - The arbiter is in IDLE the cycle after RESP. A pending request there is granted, so SETUP starts at RESP+2.
  - The minimum spacing between shared-bus transfers is 4 cycles.
- Timeout
  - The counter clears on entry to SETUP.
  - With TIMEOUT=T and no pready, RESP is entered after exactly T ACCESS cycles.
- Simultaneous APB_pready and timeout expiry in the same cycle: pready wins and the real response is returned.

## Structure
- Package `apb_arb_pkg` holds:
  - the state enum (IDLE/SETUP/ACCESS/RESP);
  - grant encoding localparams GNT_M0=0, GNT_M1=1.
- Sub-module `apb_rr_pick` (combinational plus the last-grant flop):
  - inputs: req[1:0], grant-enable strobe;
  - outputs: the winner index.
- The top module holds the FSM, capture registers, timeout counter and response demux.

## Test plan
- m0-only write, paddr=0x80000010, pdata=0xDEADBEEF, pstb=4'hF, zero-wait slave -> APB_psel at N+1, APB_penable at N+2, m0_pready pulse at N+3 with m0_perr=0; m1_pready stays 0.
- m0 and m1 both request in the same cycle after reset -> m0 granted first, m1 second. Repeat both requesting -> strict alternation m0, m1, m0, m1.
- m1 read at 0x0000_0100, slave inserts 3 wait states, APB_prdata=0x12345678 -> m1_prdata=0x12345678, m1_pready 6 cycles after request.
- TIMEOUT=8, slave never asserts pready -> exactly 8 ACCESS cycles, then m0_pready=1, m0_perr=1, m0_prdata=0.
- APB_PRESET pulse during ACCESS -> all outputs 0 asynchronously, no requester pready; next request after release served normally, with m0 winning a tie.
- APB_perr=1 returned with APB_pready on m1 write -> m1_perr=1 for the single pready cycle, then 0.
